// File: rtl/variable_node_processing_unit.sv
// Degree-4 variable-node processing unit for the QC-LDPC min-sum decoder.
// Sums the channel LLR with four check-to-variable messages in a wide accumulator.
// It produces four extrinsic messages (total minus own message) and a hard decision.
// All outputs are registered, so the latency is one cycle at full throughput.
// Optional feature macro: VNU_SATURATE_EN
//   defined   -> extrinsic messages are clipped to the signed DW-bit range
//   undefined -> extrinsic messages wrap (low DW bits kept), no clipping logic
module variable_node_processing_unit #(
    parameter int DW = 16,
    parameter int SW = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] I1,
    input  logic signed [DW-1:0] I2,
    input  logic signed [DW-1:0] I3,
    input  logic signed [DW-1:0] I4,
    input  logic signed [DW-1:0] Z,
    output logic signed [DW-1:0] L1,
    output logic signed [DW-1:0] L2,
    output logic signed [DW-1:0] L3,
    output logic signed [DW-1:0] L4,
    output logic                 C
);

`ifdef VNU_SATURATE_EN
    // Extrinsic sums are kept at full width so the clipper sees the exact value.
    localparam int EW = SW;
    localparam logic signed [SW-1:0] SAT_HI = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic [DW-1:0] fit(input logic signed [EW-1:0] e);
        logic [DW-1:0] res;
        if (e > SAT_HI) begin
            res = {1'b0, {(DW-1){1'b1}}};
        end else if (e < SAT_LO) begin
            res = {1'b1, {(DW-1){1'b0}}};
        end else begin
            res = e[DW-1:0];
        end
        return res;
    endfunction
`else
    // Wrapping only needs the low DW bits of each extrinsic sum.
    localparam int EW = DW;

    function automatic logic [DW-1:0] fit(input logic signed [EW-1:0] e);
        return e;
    endfunction
`endif

    logic signed [SW-1:0] i1_ext_s;
    logic signed [SW-1:0] i2_ext_s;
    logic signed [SW-1:0] i3_ext_s;
    logic signed [SW-1:0] i4_ext_s;
    logic signed [SW-1:0] z_ext_s;
    logic signed [SW-1:0] t_s;
    logic signed [EW-1:0] e1_s;
    logic signed [EW-1:0] e2_s;
    logic signed [EW-1:0] e3_s;
    logic signed [EW-1:0] e4_s;
    logic        [DW-1:0] l1_next_s;
    logic        [DW-1:0] l2_next_s;
    logic        [DW-1:0] l3_next_s;
    logic        [DW-1:0] l4_next_s;
    logic                 c_next_s;

    logic        [DW-1:0] l1_r;
    logic        [DW-1:0] l2_r;
    logic        [DW-1:0] l3_r;
    logic        [DW-1:0] l4_r;
    logic                 c_r;

    // Sign-extend, form the exact total and the four extrinsic sums, then fit to DW bits.
    always_comb begin
        i1_ext_s  = {{(SW-DW){I1[DW-1]}}, I1};
        i2_ext_s  = {{(SW-DW){I2[DW-1]}}, I2};
        i3_ext_s  = {{(SW-DW){I3[DW-1]}}, I3};
        i4_ext_s  = {{(SW-DW){I4[DW-1]}}, I4};
        z_ext_s   = {{(SW-DW){Z[DW-1]}}, Z};
        t_s       = z_ext_s + i1_ext_s + i2_ext_s + i3_ext_s + i4_ext_s;
        e1_s      = EW'(t_s - i1_ext_s);
        e2_s      = EW'(t_s - i2_ext_s);
        e3_s      = EW'(t_s - i3_ext_s);
        e4_s      = EW'(t_s - i4_ext_s);
        l1_next_s = fit(e1_s);
        l2_next_s = fit(e2_s);
        l3_next_s = fit(e3_s);
        l4_next_s = fit(e4_s);
        // The hard decision comes from the exact wide total; zero counts as a 0 bit.
        c_next_s  = t_s[SW-1];
    end

    // Output register stage; reset clears every output immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l1_r <= {DW{1'b0}};
            l2_r <= {DW{1'b0}};
            l3_r <= {DW{1'b0}};
            l4_r <= {DW{1'b0}};
            c_r  <= 1'b0;
        end else begin
            l1_r <= l1_next_s;
            l2_r <= l2_next_s;
            l3_r <= l3_next_s;
            l4_r <= l4_next_s;
            c_r  <= c_next_s;
        end
    end

    assign L1 = l1_r;
    assign L2 = l2_r;
    assign L3 = l3_r;
    assign L4 = l4_r;
    assign C  = c_r;

endmodule

// File: tb/tb_variable_node_processing_unit.sv
// Self-checking bench for variable_node_processing_unit (default DW=16, SW=19).
// An integer-arithmetic reference model predicts every cycle's outputs.
// Hand-computed literal vectors pin the reference model itself.
// Honours VNU_SATURATE_EN in the same way as the design.
module tb_variable_node_processing_unit;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] i1 = 16'h0000;
    logic [DW-1:0] i2 = 16'h0000;
    logic [DW-1:0] i3 = 16'h0000;
    logic [DW-1:0] i4 = 16'h0000;
    logic [DW-1:0] z  = 16'h0000;
    logic [DW-1:0] l1;
    logic [DW-1:0] l2;
    logic [DW-1:0] l3;
    logic [DW-1:0] l4;
    logic          c;

    int            tests = 0;
    int            fails = 0;
    bit            check_en = 1'b0;
    logic [3:0][DW-1:0] exp_l = '0;
    logic          exp_c = 1'b0;

    variable_node_processing_unit dut (
        .clk(clk), .rst(rst),
        .I1(i1), .I2(i2), .I3(i3), .I4(i4), .Z(z),
        .L1(l1), .L2(l2), .L3(l3), .L4(l4), .C(c)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Fit an exact integer extrinsic value into a DW-bit message.
    function automatic logic [DW-1:0] fit_m(input int e);
        logic [31:0] ev;
        ev = e;
`ifdef VNU_SATURATE_EN
        if (e > 32767) return 16'h7FFF;
        else if (e < -32768) return 16'h8000;
        else return ev[15:0];
`else
        return ev[15:0];
`endif
    endfunction

    // Reference: plain signed integer sums, no width tricks.
    task automatic model(input logic [DW-1:0] a, b, cc, d, zz,
                         output logic [3:0][DW-1:0] o, output logic oc);
        int ins[4];
        int t;
        ins[0] = int'($signed(a));
        ins[1] = int'($signed(b));
        ins[2] = int'($signed(cc));
        ins[3] = int'($signed(d));
        t = int'($signed(zz)) + ins[0] + ins[1] + ins[2] + ins[3];
        for (int k = 0; k < 4; k++) o[k] = fit_m(t - ins[k]);
        oc = (t < 0);
    endtask

    // Predict what the outputs must hold after each edge (or after reset).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_l = '0;
            exp_c = 1'b0;
        end else begin
            model(i1, i2, i3, i4, z, exp_l, exp_c);
        end
    end

    // Cycle-by-cycle comparison against the prediction, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            tests++;
            if ({l4, l3, l2, l1} !== exp_l || c !== exp_c) begin
                fails++;
                $display("FAIL stream t=%0t got L=%h %h %h %h C=%b expected L=%h %h %h %h C=%b",
                         $time, l1, l2, l3, l4, c, exp_l[0], exp_l[1], exp_l[2], exp_l[3], exp_c);
            end
        end
    end

    task automatic check_lit(input string name, input logic [DW-1:0] e1, e2, e3, e4,
                             input logic ec);
        tests++;
        if (l1 !== e1 || l2 !== e2 || l3 !== e3 || l4 !== e4 || c !== ec) begin
            fails++;
            $display("FAIL %s got L=%h %h %h %h C=%b expected L=%h %h %h %h C=%b",
                     name, l1, l2, l3, l4, c, e1, e2, e3, e4, ec);
        end
    endtask

    task automatic drive(input logic [DW-1:0] a, b, cc, d, zz);
        @(negedge clk);
        i1 = a; i2 = b; i3 = cc; i4 = d; z = zz;
    endtask

    task automatic drive_rand();
        logic [31:0] r[5];
        for (int k = 0; k < 5; k++) begin
            case ($urandom_range(0, 5))
                0:       r[k] = 32'h0000_7FFF;
                1:       r[k] = 32'h0000_8000;
                default: r[k] = $urandom;
            endcase
        end
        drive(r[0][15:0], r[1][15:0], r[2][15:0], r[3][15:0], r[4][15:0]);
    endtask

    task automatic directed(input string name, input logic [DW-1:0] a, b, cc, d, zz,
                            input logic [DW-1:0] e1, e2, e3, e4, input logic ec);
        drive(a, b, cc, d, zz);
        @(posedge clk);
        #1;
        check_lit(name, e1, e2, e3, e4, ec);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_lit("reset_async", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        check_en = 1'b1;
        // Inputs toggle while reset is held; outputs must stay clear.
        for (int n = 0; n < 4; n++) drive_rand();
        @(posedge clk);
        #1 check_lit("reset_hold", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        directed("positive", 16'd5, 16'd10, 16'd15, 16'd20, 16'd3,
                 16'h0030, 16'h002B, 16'h0026, 16'h0021, 1'b0);
        directed("negative", 16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8, 16'hFFFE,
                 16'hFFE9, 16'hFFEA, 16'hFFEB, 16'hFFEC, 1'b1);
`ifdef VNU_SATURATE_EN
        directed("ovf_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0);
        directed("ovf_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
`else
        directed("ovf_pos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                 16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC, 1'b0);
        directed("ovf_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
`endif
        directed("zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        // T == 0 with nonzero messages: C stays 0.
        directed("t_zero", 16'd1, 16'hFFFF, 16'd2, 16'hFFFE, 16'h0000,
                 16'hFFFF, 16'h0001, 16'hFFFE, 16'h0002, 1'b0);

        // Back-to-back random stream.
        for (int n = 0; n < 40; n++) drive_rand();

        // Reset mid-stream, away from any clock edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_lit("reset_mid", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        drive_rand();
        drive_rand();
        rst = 1'b0;

        for (int n = 0; n < 12; n++) drive_rand();
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
